iob_eth_phy_adapter: RTL and testbench

IOB_ETH_PHY_ADAPTER -- requirements
Module: iob_eth_phy_adapter

---
 rtl/iob_eth_phy_pkg.sv | 17 +
 rtl/iob_eth_phy_rst_seq.sv | 57 +++++
 rtl/iob_eth_phy_adapter.sv | 140 ++++++++++++++
 tb/tb_iob_eth_phy_adapter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_phy_pkg.sv
// Shared encodings for the Ethernet PHY adapter: sequencer and TX state codes,
// plus the symbols-per-byte derivation used by both datapaths.
package iob_eth_phy_pkg;

  localparam logic [1:0] SEQ_HOLD   = 2'd0;
  localparam logic [1:0] SEQ_SETTLE = 2'd1;
  localparam logic [1:0] SEQ_RDY    = 2'd2;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SHIFT = 2'd1;
  localparam logic [1:0] TX_GAP   = 2'd2;

  function automatic int syms_per_byte(input int dw);
    return 8 / dw;
  endfunction

endpackage

// File: rtl/iob_eth_phy_rst_seq.sv
// PHY reset sequencer: holds phy_rst_n low, waits for the PHY to settle, then
// raises ready. Outputs decode directly from the state register (no extra latency).
module iob_eth_phy_rst_seq
  import iob_eth_phy_pkg::*;
#(
  parameter int RST_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 2000
) (
  input  logic clk,
  input  logic rst,
  output logic phy_rst_n,
  output logic ready
);

  // One counter serves both timed phases, so it is sized for the longer one.
  localparam int CW = $clog2((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEQ_HOLD;
      cnt   <= '0;
    end else begin
      case (state)
        SEQ_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= SEQ_SETTLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SEQ_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= SEQ_RDY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SEQ_RDY: cnt <= '0;
        default: begin
          state <= SEQ_HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign phy_rst_n = (state != SEQ_HOLD);
  assign ready     = (state == SEQ_RDY);

endmodule

// File: rtl/iob_eth_phy_adapter.sv
// Byte <-> MII/RMII/GMII symbol adapter with PHY reset sequencing. TX: first symbol
// one cycle after accept, tx_ready only at IDLE or last symbol of a non-last byte.
module iob_eth_phy_adapter
  import iob_eth_phy_pkg::*;
#(
  parameter int PHY_DW        = 4,
  parameter int RST_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 2000,
  parameter int IFG_CYCLES    = 12
) (
  input  logic              clk,
  input  logic              rst,
  output logic              phy_rst_n,
  output logic              ready,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic [PHY_DW-1:0] phy_tx_d,
  output logic              phy_tx_en,
  input  logic [PHY_DW-1:0] phy_rx_d,
  input  logic              phy_rx_dv,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              rx_end,
  output logic              rx_err
);

  localparam int N  = syms_per_byte(PHY_DW);
  localparam int SW = $clog2(N) + 1;
  localparam int GW = $clog2(IFG_CYCLES) + 1;
  localparam logic [SW-1:0] SYM_LAST = SW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IFG_CYCLES - 1);

  iob_eth_phy_rst_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_rst_seq (
    .clk      (clk),
    .rst      (rst),
    .phy_rst_n(phy_rst_n),
    .ready    (ready)
  );

  logic [1:0]    tx_state;
  logic [7:0]    tx_sh;
  logic          tx_lst;
  logic [SW-1:0] tx_sym;
  logic [GW-1:0] tx_gap;
  logic          sym_end;
  logic          tx_fire;

  assign sym_end  = (tx_sym == SYM_LAST);
  assign tx_ready = ready && ((tx_state == TX_IDLE) ||
                              ((tx_state == TX_SHIFT) && sym_end && !tx_lst));
  assign tx_fire  = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_sh    <= '0;
      tx_lst   <= 1'b0;
      tx_sym   <= '0;
      tx_gap   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_fire) begin
            tx_state <= TX_SHIFT;
            tx_sh    <= tx_data;
            tx_lst   <= tx_last;
            tx_sym   <= '0;
          end
        end
        TX_SHIFT: begin
          if (!sym_end) begin
            tx_sh  <= tx_sh >> PHY_DW;
            tx_sym <= tx_sym + SW'(1);
          end else if (tx_fire) begin
            tx_sh  <= tx_data;
            tx_lst <= tx_last;
            tx_sym <= '0;
          end else begin
            // End of frame and underrun both fall through to the enforced gap.
            tx_state <= TX_GAP;
            tx_gap   <= '0;
          end
        end
        TX_GAP: begin
          if (tx_gap == GAP_LAST) tx_state <= TX_IDLE;
          else                    tx_gap   <= tx_gap + GW'(1);
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign phy_tx_en = (tx_state == TX_SHIFT);
  assign phy_tx_d  = phy_tx_en ? tx_sh[PHY_DW-1:0] : '0;

  logic [7:0]    rx_sh;
  logic [7:0]    rx_next;
  logic [SW-1:0] rx_cnt;
  logic          rx_dv_q;

  // New symbols enter at the top so the first one received ends up in the LSBs.
  assign rx_next = 8'({phy_rx_d, rx_sh} >> PHY_DW);

  always_ff @(posedge clk) begin
    if (rst || !ready) begin
      rx_sh    <= '0;
      rx_cnt   <= '0;
      rx_dv_q  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_end   <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_dv_q  <= phy_rx_dv;
      rx_valid <= 1'b0;
      rx_end   <= 1'b0;
      rx_err   <= 1'b0;
      if (phy_rx_dv) begin
        rx_sh <= rx_next;
        if (rx_cnt == SYM_LAST) begin
          rx_cnt   <= '0;
          rx_valid <= 1'b1;
          rx_data  <= rx_next;
        end else begin
          rx_cnt <= rx_cnt + SW'(1);
        end
      end else if (rx_dv_q) begin
        rx_end <= 1'b1;
        rx_err <= (rx_cnt != '0);
        rx_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iob_eth_phy_adapter.sv
// Bench for iob_eth_phy_adapter: an MII (4-bit) and an RMII (2-bit) instance share
// clock and reset; expected TX symbols and RX bytes are queued as stimulus is driven.
module tb_iob_eth_phy_adapter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] m_tx_data;
  logic       m_tx_valid, m_tx_last, m_tx_ready;
  logic [3:0] m_phy_tx_d, m_phy_rx_d;
  logic       m_phy_tx_en, m_phy_rx_dv;
  logic [7:0] m_rx_data;
  logic       m_rx_valid, m_rx_end, m_rx_err, m_phy_rst_n, m_ready;

  logic [7:0] r_tx_data;
  logic       r_tx_valid, r_tx_last, r_tx_ready;
  logic [1:0] r_phy_tx_d, r_phy_rx_d;
  logic       r_phy_tx_en, r_phy_rx_dv;
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_rx_end, r_rx_err, r_phy_rst_n, r_ready;

  iob_eth_phy_adapter #(.PHY_DW(4), .RST_CYCLES(10), .SETTLE_CYCLES(20), .IFG_CYCLES(12)) u_mii (
    .clk(clk), .rst(rst), .phy_rst_n(m_phy_rst_n), .ready(m_ready),
    .tx_data(m_tx_data), .tx_valid(m_tx_valid), .tx_last(m_tx_last), .tx_ready(m_tx_ready),
    .phy_tx_d(m_phy_tx_d), .phy_tx_en(m_phy_tx_en), .phy_rx_d(m_phy_rx_d), .phy_rx_dv(m_phy_rx_dv),
    .rx_data(m_rx_data), .rx_valid(m_rx_valid), .rx_end(m_rx_end), .rx_err(m_rx_err)
  );

  iob_eth_phy_adapter #(.PHY_DW(2), .RST_CYCLES(10), .SETTLE_CYCLES(20), .IFG_CYCLES(12)) u_rmii (
    .clk(clk), .rst(rst), .phy_rst_n(r_phy_rst_n), .ready(r_ready),
    .tx_data(r_tx_data), .tx_valid(r_tx_valid), .tx_last(r_tx_last), .tx_ready(r_tx_ready),
    .phy_tx_d(r_phy_tx_d), .phy_tx_en(r_phy_tx_en), .phy_rx_d(r_phy_rx_d), .phy_rx_dv(r_phy_rx_dv),
    .rx_data(r_rx_data), .rx_valid(r_rx_valid), .rx_end(r_rx_end), .rx_err(r_rx_err)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] tx_q[$];
  logic [7:0] m_rxb_q[$];
  logic [7:0] r_rxb_q[$];
  logic       m_rxe_q[$];
  logic       r_rxe_q[$];

  logic [1:0] rmii_syms[4] = '{2'd1, 2'd1, 2'd2, 2'd2};
  logic [3:0] frag_syms[3] = '{4'h6, 4'h9, 4'hF};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Output-side scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_phy_tx_en) begin
      if (tx_q.size() == 0) chk("tx_unexpected_en", 32'(m_phy_tx_en), 0);
      else                  chk("tx_symbol", 32'(m_phy_tx_d), 32'(tx_q.pop_front()));
    end else begin
      chk("tx_idle_d", 32'(m_phy_tx_d), 0);
    end
    chk("r_tx_idle", 32'({r_phy_tx_en, r_phy_tx_d}), 0);

    if (m_rx_valid) begin
      if (m_rxb_q.size() == 0) chk("m_rx_unexpected", 32'(m_rx_valid), 0);
      else                     chk("m_rx_byte", 32'(m_rx_data), 32'(m_rxb_q.pop_front()));
    end
    if (m_rx_end) begin
      if (m_rxe_q.size() == 0) chk("m_rx_end_unexpected", 32'(m_rx_end), 0);
      else                     chk("m_rx_err", 32'(m_rx_err), 32'(m_rxe_q.pop_front()));
    end else begin
      chk("m_rx_err_alone", 32'(m_rx_err), 0);
    end

    if (r_rx_valid) begin
      if (r_rxb_q.size() == 0) chk("r_rx_unexpected", 32'(r_rx_valid), 0);
      else                     chk("r_rx_byte", 32'(r_rx_data), 32'(r_rxb_q.pop_front()));
    end
    if (r_rx_end) begin
      if (r_rxe_q.size() == 0) chk("r_rx_end_unexpected", 32'(r_rx_end), 0);
      else                     chk("r_rx_err", 32'(r_rx_err), 32'(r_rxe_q.pop_front()));
    end else begin
      chk("r_rx_err_alone", 32'(r_rx_err), 0);
    end
  end

  // Starts on the falling edge where rst was just released; i counts cycles since.
  task automatic seq_check(input bit drive_rx);
    for (int i = 0; i < 35; i++) begin
      chk("phy_rst_n", 32'(m_phy_rst_n), 32'(i >= 10));
      chk("ready", 32'(m_ready), 32'(i >= 30));
      chk("tx_ready_seq", 32'(m_tx_ready), 32'(i >= 30));
      chk("r_phy_rst_n", 32'(r_phy_rst_n), 32'(i >= 10));
      chk("r_tx_ready_seq", 32'(r_tx_ready), 32'(i >= 30));
      if (drive_rx) begin
        if (i < 30) chk("rx_gated", 32'({r_rx_valid, r_rx_end, r_rx_err}), 0);
        r_phy_rx_dv = (i < 26);
        r_phy_rx_d  = 2'(i);
      end
      @(negedge clk);
    end
    r_phy_rx_dv = 1'b0;
  endtask

  // Called on the falling edge showing the final symbol; counts idle cycles until tx_ready.
  task automatic gap_wait(input string tag);
    int gap = 0;
    @(negedge clk);
    while (!m_tx_ready && gap < 40) begin
      chk({tag, "_en_low"}, 32'(m_phy_tx_en), 0);
      gap++;
      @(negedge clk);
    end
    chk(tag, 32'(gap), 12);
  endtask

  initial begin
    m_tx_data = '0; m_tx_valid = 1'b0; m_tx_last = 1'b0; m_phy_rx_d = '0; m_phy_rx_dv = 1'b0;
    r_tx_data = '0; r_tx_valid = 1'b0; r_tx_last = 1'b0; r_phy_rx_d = '0; r_phy_rx_dv = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_phy_rst_n", 32'(m_phy_rst_n), 0);
    chk("rst_ready", 32'(m_ready), 0);
    chk("rst_tx_ready", 32'(m_tx_ready), 0);
    chk("rst_tx_en", 32'(m_phy_tx_en), 0);
    chk("rst_rx_out", 32'({m_rx_data, m_rx_valid, m_rx_end, m_rx_err}), 0);
    rst = 1'b0;
    seq_check(1'b1);

    // Two-byte frame A5, 3C(last)
    chk("tx_ready_idle", 32'(m_tx_ready), 1);
    m_tx_data = 8'hA5; m_tx_valid = 1'b1; m_tx_last = 1'b0;
    tx_q.push_back(4'h5); tx_q.push_back(4'hA);
    @(negedge clk);
    chk("tx_en_s0", 32'(m_phy_tx_en), 1);
    chk("tx_ready_s0", 32'(m_tx_ready), 0);
    m_tx_data = 8'h3C; m_tx_last = 1'b1;
    tx_q.push_back(4'hC); tx_q.push_back(4'h3);
    @(negedge clk);
    chk("tx_en_s1", 32'(m_phy_tx_en), 1);
    chk("tx_ready_b2b", 32'(m_tx_ready), 1);
    @(negedge clk);
    chk("tx_en_s2", 32'(m_phy_tx_en), 1);
    chk("tx_ready_last_s0", 32'(m_tx_ready), 0);
    m_tx_valid = 1'b0; m_tx_last = 1'b0;
    @(negedge clk);
    chk("tx_en_s3", 32'(m_phy_tx_en), 1);
    chk("tx_ready_last_s1", 32'(m_tx_ready), 0);
    gap_wait("ifg_frame");

    // Underrun after the first byte of a frame
    m_tx_data = 8'h5A; m_tx_valid = 1'b1; m_tx_last = 1'b0;
    tx_q.push_back(4'hA); tx_q.push_back(4'h5);
    @(negedge clk);
    chk("ur_en_s0", 32'(m_phy_tx_en), 1);
    m_tx_valid = 1'b0;
    @(negedge clk);
    chk("ur_en_s1", 32'(m_phy_tx_en), 1);
    chk("ur_tx_ready", 32'(m_tx_ready), 1);
    gap_wait("ifg_underrun");

    // RMII receive: symbols 1,1,2,2 -> A5
    r_rxb_q.push_back(8'hA5); r_rxe_q.push_back(1'b0);
    foreach (rmii_syms[k]) begin
      r_phy_rx_dv = 1'b1; r_phy_rx_d = rmii_syms[k];
      @(negedge clk);
    end
    chk("r_rx_valid_t", 32'(r_rx_valid), 1);
    chk("r_rx_end_early", 32'(r_rx_end), 0);
    r_phy_rx_dv = 1'b0;
    @(negedge clk);
    chk("r_rx_end_t", 32'(r_rx_end), 1);
    chk("r_rx_err_t", 32'(r_rx_err), 0);
    chk("r_rx_valid_once", 32'(r_rx_valid), 0);
    @(negedge clk);

    // MII fragment: three nibbles -> one byte then end+err
    m_rxb_q.push_back(8'h96); m_rxe_q.push_back(1'b1);
    foreach (frag_syms[k]) begin
      m_phy_rx_dv = 1'b1; m_phy_rx_d = frag_syms[k];
      @(negedge clk);
    end
    chk("frag_end_early", 32'(m_rx_end), 0);
    m_phy_rx_dv = 1'b0;
    @(negedge clk);
    chk("frag_end", 32'(m_rx_end), 1);
    chk("frag_err", 32'(m_rx_err), 1);
    @(negedge clk);

    // Reset during the third TX symbol with an RX frame in flight
    chk("mr_tx_ready", 32'(m_tx_ready), 1);
    m_tx_data = 8'hC3; m_tx_valid = 1'b1; m_tx_last = 1'b0;
    tx_q.push_back(4'h3); tx_q.push_back(4'hC);
    m_phy_rx_dv = 1'b1; m_phy_rx_d = 4'h4; m_rxb_q.push_back(8'h74);
    @(negedge clk);
    m_tx_data = 8'h81; m_tx_last = 1'b1;
    tx_q.push_back(4'h1); tx_q.push_back(4'h8);
    m_phy_rx_d = 4'h7;
    @(negedge clk);
    m_phy_rx_d = 4'h2;
    @(negedge clk);
    chk("mr_en_s2", 32'(m_phy_tx_en), 1);
    rst = 1'b1; m_tx_valid = 1'b0; m_tx_last = 1'b0; m_phy_rx_dv = 1'b0;
    @(negedge clk);
    chk("mr_tx_en", 32'(m_phy_tx_en), 0);
    chk("mr_phy_rst_n", 32'(m_phy_rst_n), 0);
    chk("mr_ready", 32'(m_ready), 0);
    chk("mr_tx_ready", 32'(m_tx_ready), 0);
    chk("mr_rx_pulse", 32'({m_rx_end, m_rx_err}), 0);
    tx_q.delete();
    @(negedge clk);
    chk("mr_rx_pulse2", 32'({m_rx_end, m_rx_err}), 0);
    rst = 1'b0;
    seq_check(1'b0);

    chk("tx_q_drained", 32'(tx_q.size()), 0);
    chk("rx_q_drained", 32'(m_rxb_q.size() + r_rxb_q.size() + m_rxe_q.size() + r_rxe_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
